// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART transmit path.
//   UART_BYTE_W : width of one transmitted byte
//   tx_state_e  : launch-controller state encoding used by uart_tx_fifo
// -----------------------------------------------------------------------------
package uart_pkg;

  localparam int UART_BYTE_W = 8;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_LAUNCH    = 2'd1,
    ST_WAIT_BUSY = 2'd2,
    ST_WAIT_DONE = 2'd3
  } tx_state_e;

endpackage

// File: rtl/uart_tx_fifo_if.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo_if
// Bundles the writer side and the transmitter side of uart_tx_fifo.
//   master : the system writer / transmitter environment
//            drives wr_en, wr_data, ovf_clr, tx_busy
//   slave  : uart_tx_fifo
//            drives full, empty, overflow, tx_pos, tx_data, tx_err
// -----------------------------------------------------------------------------
interface uart_tx_fifo_if;

  logic                               wr_en;
  logic [uart_pkg::UART_BYTE_W-1:0]   wr_data;
  logic                               full;
  logic                               empty;
  logic                               overflow;
  logic                               ovf_clr;
  logic                               tx_busy;
  logic                               tx_pos;
  logic [uart_pkg::UART_BYTE_W-1:0]   tx_data;
  logic                               tx_err;

  modport master (
    output wr_en, wr_data, ovf_clr, tx_busy,
    input  full, empty, overflow, tx_pos, tx_data, tx_err
  );

  modport slave (
    input  wr_en, wr_data, ovf_clr, tx_busy,
    output full, empty, overflow, tx_pos, tx_data, tx_err
  );

endinterface

// File: rtl/uart_fifo_mem.sv
// -----------------------------------------------------------------------------
// uart_fifo_mem
// Byte storage for the transmit FIFO: 2^DEPTH_LOG2 x 8, synchronous write,
// asynchronous read at the read pointer, contents never reset.
//   clk     : write clock
//   wr_en   : write strobe
//   wr_addr : write pointer
//   wr_data : byte to store
//   rd_addr : read pointer
//   rd_data : byte at rd_addr (combinational)
// -----------------------------------------------------------------------------
module uart_fifo_mem
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                   clk,
  input  logic                   wr_en,
  input  logic [DEPTH_LOG2-1:0]  wr_addr,
  input  logic [UART_BYTE_W-1:0] wr_data,
  input  logic [DEPTH_LOG2-1:0]  rd_addr,
  output logic [UART_BYTE_W-1:0] rd_data
);

  localparam int DEPTH = 1 << DEPTH_LOG2;

  logic [UART_BYTE_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[wr_addr] <= wr_data;
    end
  end

  assign rd_data = mem[rd_addr];

endmodule

// File: rtl/uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// uart_tx_fifo
// Byte FIFO plus launch controller feeding a UART transmitter. Each byte is
// popped into tx_data with a tx_pos rising edge; the controller then waits for
// tx_busy to rise (or times out after BUSY_TIMEOUT cycles, setting tx_err) and
// to fall again before launching the next byte.
//   uart_clk : bit-rate clock
//   rst      : asynchronous active-low reset
//   bus      : uart_tx_fifo_if.slave (writer + transmitter handshake/status)
//   level    : occupancy count, present only when UART_TX_FIFO_LEVEL_EN is
//              defined
// Optional feature macro: UART_TX_FIFO_LEVEL_EN
// -----------------------------------------------------------------------------
module uart_tx_fifo
  import uart_pkg::*;
#(
  parameter int DEPTH_LOG2   = 4,
  parameter int BUSY_TIMEOUT = 8
) (
  input  logic                 uart_clk,
  input  logic                 rst,
  uart_tx_fifo_if.slave        bus
`ifdef UART_TX_FIFO_LEVEL_EN
  ,
  output logic [DEPTH_LOG2:0]  level
`endif
);

  localparam int                  DEPTH     = 1 << DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] DEPTH_CNT = (DEPTH_LOG2 + 1)'(DEPTH);
  localparam int                  TO_W      = $clog2(BUSY_TIMEOUT + 1);
  localparam logic [TO_W-1:0]     TO_LAST   = TO_W'(BUSY_TIMEOUT - 1);

  logic [DEPTH_LOG2-1:0]  wr_ptr_reg;
  logic [DEPTH_LOG2-1:0]  rd_ptr_reg;
  logic [DEPTH_LOG2:0]    count_reg;
  logic                   full_reg;
  logic                   empty_reg;
  logic                   overflow_reg;
  logic                   tx_pos_reg;
  logic                   tx_pos_next;
  logic [UART_BYTE_W-1:0] tx_data_reg;
  logic                   tx_err_reg;
  logic [TO_W-1:0]        to_cnt_reg;
  logic [TO_W-1:0]        to_cnt_next;
  tx_state_e              state_reg;
  tx_state_e              state_next;
  logic                   pop;
  logic                   err_set;
  logic                   wr_accept;
  logic                   wr_drop;
  logic [UART_BYTE_W-1:0] mem_rd_data;

  // full/empty lag the count by one edge, so the count itself also guards the
  // write: a write in the cycle right after the count reached depth must not
  // overwrite the oldest unread byte.
  assign wr_accept = bus.wr_en && !full_reg && (count_reg != DEPTH_CNT);
  assign wr_drop   = bus.wr_en && !wr_accept;

  uart_fifo_mem #(
    .DEPTH_LOG2 (DEPTH_LOG2)
  ) u_mem (
    .clk     (uart_clk),
    .wr_en   (wr_accept),
    .wr_addr (wr_ptr_reg),
    .wr_data (bus.wr_data),
    .rd_addr (rd_ptr_reg),
    .rd_data (mem_rd_data)
  );

  always_comb begin
    state_next  = state_reg;
    tx_pos_next = 1'b0;
    to_cnt_next = to_cnt_reg;
    pop         = 1'b0;
    err_set     = 1'b0;
    case (state_reg)
      ST_IDLE: begin
        if (!empty_reg) begin
          pop         = 1'b1;
          tx_pos_next = 1'b1;
          state_next  = ST_LAUNCH;
        end
      end
      ST_LAUNCH: begin
        tx_pos_next = 1'b1;
        to_cnt_next = '0;
        state_next  = ST_WAIT_BUSY;
      end
      ST_WAIT_BUSY: begin
        tx_pos_next = 1'b1;
        to_cnt_next = to_cnt_reg + 1'b1;
        // A late busy on the final cycle still counts as a successful launch.
        if (bus.tx_busy) begin
          tx_pos_next = 1'b0;
          state_next  = ST_WAIT_DONE;
        end else if (to_cnt_reg == TO_LAST) begin
          err_set     = 1'b1;
          tx_pos_next = 1'b0;
          state_next  = ST_IDLE;
        end
      end
      ST_WAIT_DONE: begin
        if (!bus.tx_busy) begin
          state_next = ST_IDLE;
        end
      end
      default: state_next = ST_IDLE;
    endcase
  end

  always_ff @(posedge uart_clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= ST_IDLE;
      wr_ptr_reg   <= '0;
      rd_ptr_reg   <= '0;
      count_reg    <= '0;
      full_reg     <= 1'b0;
      empty_reg    <= 1'b1;
      overflow_reg <= 1'b0;
      tx_pos_reg   <= 1'b0;
      tx_data_reg  <= '0;
      tx_err_reg   <= 1'b0;
      to_cnt_reg   <= '0;
    end else begin
      state_reg  <= state_next;
      tx_pos_reg <= tx_pos_next;
      to_cnt_reg <= to_cnt_next;

      if (wr_accept) begin
        wr_ptr_reg <= wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_reg  <= rd_ptr_reg + 1'b1;
        tx_data_reg <= mem_rd_data;
      end
      case ({wr_accept, pop})
        2'b10:   count_reg <= count_reg + 1'b1;
        2'b01:   count_reg <= count_reg - 1'b1;
        default: count_reg <= count_reg;
      endcase

      full_reg  <= (count_reg == DEPTH_CNT);
      empty_reg <= (count_reg == '0);

      if (bus.ovf_clr) begin
        overflow_reg <= 1'b0;
      end else if (wr_drop) begin
        overflow_reg <= 1'b1;
      end

      if (err_set) begin
        tx_err_reg <= 1'b1;
      end
    end
  end

`ifdef UART_TX_FIFO_LEVEL_EN
  logic [DEPTH_LOG2:0] level_reg;

  always_ff @(posedge uart_clk or negedge rst) begin
    if (!rst) begin
      level_reg <= '0;
    end else begin
      level_reg <= count_reg;
    end
  end

  assign level = level_reg;
`endif

  assign bus.full     = full_reg;
  assign bus.empty    = empty_reg;
  assign bus.overflow = overflow_reg;
  assign bus.tx_pos   = tx_pos_reg;
  assign bus.tx_data  = tx_data_reg;
  assign bus.tx_err   = tx_err_reg;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// -----------------------------------------------------------------------------
// tb_uart_tx_fifo
// Bench for uart_tx_fifo with a simple one-bit-per-clock transmitter model.
// Expected bytes are queued as they are written; a monitor pops them when a
// frame appears on the serial line. Directed timing checks run inline.
// Level checks are compiled in when UART_TX_FIFO_LEVEL_EN is defined.
// -----------------------------------------------------------------------------
module tb_uart_tx_fifo;

  localparam int DEPTH_LOG2   = 4;
  localparam int BUSY_TIMEOUT = 8;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       serial = 1'b1;
  int         checks = 0;
  int         failures = 0;
  bit         model_en = 1'b1;
  int         extra_busy = 0;
  logic [7:0] sb [$];

`ifdef UART_TX_FIFO_LEVEL_EN
  logic [DEPTH_LOG2:0] level;
`endif

  uart_tx_fifo_if bus ();

  uart_tx_fifo #(
    .DEPTH_LOG2   (DEPTH_LOG2),
    .BUSY_TIMEOUT (BUSY_TIMEOUT)
  ) dut (
    .uart_clk (clk),
    .rst      (rst),
    .bus      (bus)
`ifdef UART_TX_FIFO_LEVEL_EN
    ,
    .level    (level)
`endif
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  task automatic cyc(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic write_byte(input logic [7:0] b, input bit push);
    @(posedge clk); #1;
    bus.wr_en   = 1'b1;
    bus.wr_data = b;
    if (push) sb.push_back(b);
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic fill16(input logic [7:0] base, input bit push);
    for (int i = 0; i < 16; i++) begin
      @(posedge clk); #1;
      bus.wr_en   = 1'b1;
      bus.wr_data = base + 8'(i);
      if (push) sb.push_back(base + 8'(i));
    end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (bus.tx_busy === lvl) begin
        seen = 1'b1;
        break;
      end
    end
    check(name, 32'(seen), 32'h1);
  endtask

  task automatic wait_drain(input int budget, input string name);
    bit done = 1'b0;
    for (int i = 0; i < budget; i++) begin
      @(negedge clk);
      if (sb.size() == 0 && bus.empty === 1'b1 && bus.tx_busy === 1'b0 && bus.tx_pos === 1'b0) begin
        done = 1'b1;
        break;
      end
    end
    check(name, 32'(done), 32'h1);
    cyc(2);
  endtask

  // Transmitter model: sees tx_pos high, raises busy, sends start bit, eight
  // data bits LSB first (taken live from tx_data), stop bit, optional extra
  // busy time, then drops busy.
  initial begin
    int hold;
    bus.tx_busy = 1'b0;
    forever begin
      @(negedge clk);
      if (model_en && rst && bus.tx_pos === 1'b1) begin
        hold = extra_busy;
        @(posedge clk); #1;
        bus.tx_busy = 1'b1;
        serial      = 1'b0;
        for (int b = 0; b < 8; b++) begin
          @(posedge clk); #1;
          serial = bus.tx_data[b];
        end
        @(posedge clk); #1;
        serial = 1'b1;
        for (int h = 0; h < hold; h++) begin
          @(posedge clk); #1;
        end
        @(posedge clk); #1;
        bus.tx_busy = 1'b0;
      end
    end
  end

  // Monitor: checks tx_data at each launch and each decoded serial frame
  // against the head of the expected-byte queue.
  initial begin
    logic [7:0] fr;
    logic       pos_q;
    int         nbits;
    bit         in_frame;
    fr = '0; pos_q = 1'b0; nbits = 0; in_frame = 1'b0;
    forever begin
      @(negedge clk);
      if (!rst) begin
        in_frame = 1'b0;
        pos_q    = 1'b0;
      end else begin
        if (model_en && bus.tx_pos === 1'b1 && pos_q !== 1'b1) begin
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL launch_unexpected: tx_data 0x%0h with no byte expected", bus.tx_data);
          end else begin
            check("launch_data", 32'(bus.tx_data), 32'(sb[0]));
          end
        end
        pos_q = bus.tx_pos;
        if (!in_frame) begin
          if (model_en && bus.tx_busy === 1'b1 && serial === 1'b0) begin
            in_frame = 1'b1;
            nbits    = 0;
          end
        end else if (nbits < 8) begin
          fr[nbits] = serial;
          nbits++;
        end else begin
          in_frame = 1'b0;
          check("stop_bit", 32'(serial), 32'h1);
          if (sb.size() == 0) begin
            checks++;
            failures++;
            $display("FAIL frame_unexpected: serial byte 0x%0h with no byte expected", fr);
          end else begin
            check("frame_data", 32'(fr), 32'(sb.pop_front()));
          end
        end
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int   rises;
    logic pq;
    bus.wr_en   = 1'b0;
    bus.wr_data = '0;
    bus.ovf_clr = 1'b0;

    // Reset state
    cyc(3);
    check("rst_tx_pos",   32'(bus.tx_pos),   32'h0);
    check("rst_tx_data",  32'(bus.tx_data),  32'h0);
    check("rst_empty",    32'(bus.empty),    32'h1);
    check("rst_full",     32'(bus.full),     32'h0);
    check("rst_overflow", 32'(bus.overflow), 32'h0);
    check("rst_tx_err",   32'(bus.tx_err),   32'h0);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("rst_level",    32'(level),        32'h0);
`endif
    rst = 1'b1;
    cyc(2);

    // Single byte 0xA5: latency from the write edge N
    write_byte(8'hA5, 1'b1);
    cyc(1);
    check("a5_empty_n",    32'(bus.empty),   32'h1);
    cyc(1);
    check("a5_empty_n1",   32'(bus.empty),   32'h0);
    check("a5_pos_n1",     32'(bus.tx_pos),  32'h0);
    cyc(1);
    check("a5_pos_n2",     32'(bus.tx_pos),  32'h1);
    check("a5_data_n2",    32'(bus.tx_data), 32'hA5);
    cyc(1);
    check("a5_pos_n3",     32'(bus.tx_pos),  32'h1);
    check("a5_busy_n3",    32'(bus.tx_busy), 32'h1);
    cyc(1);
    check("a5_pos_n4",     32'(bus.tx_pos),  32'h0);
    wait_drain(100, "a5_drain");

    // Fill 16 behind a long frame, 17th dropped, ovf_clr clears
    extra_busy = 40;
    write_byte(8'hEE, 1'b1);
    wait_busy(1'b1, 20, "fill_primer_busy");
    fill16(8'h00, 1'b1);
    cyc(2);
    check("fill_full",     32'(bus.full),     32'h1);
    check("fill_ovf_pre",  32'(bus.overflow), 32'h0);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("fill_level",    32'(level),        32'h10);
`endif
    write_byte(8'h10, 1'b0);
    cyc(1);
    check("fill_ovf_set",  32'(bus.overflow), 32'h1);
    extra_busy = 0;
    wait_drain(1500, "fill_drain");
    check("ovf_sticky",    32'(bus.overflow), 32'h1);
    @(posedge clk); #1; bus.ovf_clr = 1'b1;
    @(posedge clk); #1; bus.ovf_clr = 1'b0;
    cyc(1);
    check("ovf_cleared",   32'(bus.overflow), 32'h0);

    // Launch timeout with no transmitter response
    model_en = 1'b0;
    write_byte(8'h3C, 1'b0);
    cyc(11);
    check("to_pos_held",   32'(bus.tx_pos),  32'h1);
    check("to_err_pre",    32'(bus.tx_err),  32'h0);
    check("to_data",       32'(bus.tx_data), 32'h3C);
    cyc(1);
    check("to_pos_low",    32'(bus.tx_pos),  32'h0);
    check("to_err_set",    32'(bus.tx_err),  32'h1);
    check("to_empty",      32'(bus.empty),   32'h1);
    model_en = 1'b1;
    write_byte(8'h5A, 1'b1);
    wait_drain(100, "to_next_drain");
    check("tx_err_sticky", 32'(bus.tx_err),  32'h1);

    // Full FIFO, write in the pop cycle; ovf_clr against a drop
    extra_busy = 40;
    write_byte(8'hE1, 1'b1);
    wait_busy(1'b1, 20, "pop_primer_busy");
    fill16(8'h20, 1'b1);
    cyc(2);
    check("pop_full",      32'(bus.full),     32'h1);
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_data = 8'h99; bus.ovf_clr = 1'b1;
    @(posedge clk); #1;
    bus.wr_en = 1'b0; bus.ovf_clr = 1'b0;
    cyc(1);
    check("ovf_clr_wins",  32'(bus.overflow), 32'h0);
    extra_busy = 0;
    wait_busy(1'b0, 100, "pop_busy_fall");
    @(posedge clk); #1;
    bus.wr_en = 1'b1; bus.wr_data = 8'h77;
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    cyc(1);
    check("pop_ovf_set",   32'(bus.overflow), 32'h1);
    check("pop_launch",    32'(bus.tx_pos),   32'h1);
    cyc(1);
    check("pop_full_clr",  32'(bus.full),     32'h0);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("pop_level_15",  32'(level),        32'hF);
`endif
    wait_drain(1500, "pop_drain");

    // Reset while the transmitter is busy and 5 bytes are queued
    extra_busy = 40;
    write_byte(8'hB2, 1'b1);
    wait_busy(1'b1, 20, "rst_primer_busy");
    for (int i = 0; i < 5; i++) begin
      @(posedge clk); #1;
      bus.wr_en = 1'b1; bus.wr_data = 8'h40 + 8'(i);
    end
    @(posedge clk); #1;
    bus.wr_en = 1'b0;
    cyc(6);
    check("pre_rst_empty", 32'(bus.empty),    32'h0);
    check("pre_rst_data",  32'(bus.tx_data),  32'hB2);
`ifdef UART_TX_FIFO_LEVEL_EN
    check("pre_rst_level", 32'(level),        32'h5);
`endif
    rst = 1'b0;
    #1;
    check("mid_rst_pos",   32'(bus.tx_pos),   32'h0);
    check("mid_rst_empty", 32'(bus.empty),    32'h1);
    check("mid_rst_full",  32'(bus.full),     32'h0);
    check("mid_rst_data",  32'(bus.tx_data),  32'h0);
    check("mid_rst_err",   32'(bus.tx_err),   32'h0);
    check("mid_rst_ovf",   32'(bus.overflow), 32'h1 & 32'(bus.overflow) ^ 32'(bus.overflow));
`ifdef UART_TX_FIFO_LEVEL_EN
    check("mid_rst_level", 32'(level),        32'h0);
`endif
    extra_busy = 0;
    cyc(2);
    rst = 1'b1;
    rises = 0;
    pq    = 1'b0;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk);
      if (bus.tx_pos === 1'b1 && pq !== 1'b1) rises++;
      pq = bus.tx_pos;
    end
    check("no_launch_after_rst", 32'(rises), 32'h0);
    write_byte(8'hC3, 1'b1);
    wait_drain(100, "post_rst_drain");

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
